pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage rv32 core (IF, DE, EXE, ACC, WB). It decides every cycle which pipeline registers advance, where bubbles and flushes are inserted, and which forwarding source feeds the DE operands. It resolves four cases: data-memory wait, branch/jump redirect, load-use hazard and instruction-fetch wait. It sits beside the datapath and drives its stage enables and operand muxes.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_ctrl_fwd_unit.sv | 23 ++
 rtl/pipe_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, forwarding codes and operand-select helper
package pipe_ctrl_pkg;
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;
  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EXE  = 2'b01;
  localparam logic [1:0] FWD_ACC  = 2'b10;
  localparam logic [31:0] NOP     = 32'h00000013;
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] exe_rd,
                                         input logic [4:0] acc_rd, input logic exe_fwd,
                                         input logic acc_wb_en);
    return (rs == 5'd0) ? FWD_RF :
           (exe_fwd && exe_rd == rs) ? FWD_EXE :
           (acc_wb_en && acc_rd == rs) ? FWD_ACC : FWD_RF;
  endfunction
endpackage

// File: rtl/pipe_ctrl_fwd_unit.sv
// pipe_fwd_unit: operand forwarding select and load-use hazard detection
import pipe_ctrl_pkg::*;
module pipe_fwd_unit (
  input  logic [4:0] de_rs1_i,
  input  logic [4:0] de_rs2_i,
  input  logic       de_use_rs1_i,
  input  logic       de_use_rs2_i,
  input  logic [4:0] exe_rd_i,
  input  logic       exe_wb_en_i,
  input  logic       exe_is_load_i,
  input  logic [4:0] acc_rd_i,
  input  logic       acc_wb_en_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o,
  output logic       load_use_o
);
  logic exe_fwd;
  assign exe_fwd    = exe_wb_en_i && !exe_is_load_i;
  assign fwd_a_o    = fwd_sel(de_rs1_i, exe_rd_i, acc_rd_i, exe_fwd, acc_wb_en_i);
  assign fwd_b_o    = fwd_sel(de_rs2_i, exe_rd_i, acc_rd_i, exe_fwd, acc_wb_en_i);
  assign load_use_o = exe_is_load_i && exe_wb_en_i && exe_rd_i != 5'd0 &&
                      ((de_use_rs1_i && de_rs1_i == exe_rd_i) || (de_use_rs2_i && de_rs2_i == exe_rd_i));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline sequencer (stalls, flushes, forwarding); optional PIPE_CTRL_PERF_EN perf counters
import pipe_ctrl_pkg::*;
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] de_rs1,
  input  logic [4:0] de_rs2,
  input  logic       de_use_rs1,
  input  logic       de_use_rs2,
  input  logic [4:0] exe_rd,
  input  logic       exe_wb_en,
  input  logic       exe_is_load,
  input  logic       exe_redirect,
  input  logic [4:0] acc_rd,
  input  logic       acc_wb_en,
  input  logic       acc_mem_req,
  input  logic       dmem_ready,
  input  logic       imem_ready,
  output logic       en_if,
  output logic       en_de,
  output logic       en_exe,
  output logic       en_acc,
  output logic       en_wb,
  output logic       flush_de,
  output logic       bubble_exe,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushes
`endif
);
  logic [1:0] state_q, state_d;
  logic       pend_q, pend_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       to_q, to_d;
  logic [1:0] fa, fb;
  logic       load_use, stall, in_redir, en_back;

  pipe_fwd_unit u_fwd (
    .de_rs1_i      (de_rs1),
    .de_rs2_i      (de_rs2),
    .de_use_rs1_i  (de_use_rs1),
    .de_use_rs2_i  (de_use_rs2),
    .exe_rd_i      (exe_rd),
    .exe_wb_en_i   (exe_wb_en),
    .exe_is_load_i (exe_is_load),
    .acc_rd_i      (acc_rd),
    .acc_wb_en_i   (acc_wb_en),
    .fwd_a_o       (fa),
    .fwd_b_o       (fb),
    .load_use_o    (load_use)
  );

  // Priority chain for stage enables: reset, memory wait, redirect, load-use, fetch wait
  always_comb begin
    stall    = !rst && !dmem_ready && (acc_mem_req || state_q == MEM_WAIT);
    in_redir = state_q == REDIRECT;
    {en_if, en_de, en_back, flush_de, bubble_exe} =
      rst                      ? 5'b00011 :
      stall                    ? 5'b00000 :
      (exe_redirect || in_redir) ? {4'b1111, exe_redirect} :
      load_use                 ? 5'b00101 :
      !imem_ready              ? 5'b01110 : 5'b11100;
    en_exe      = en_back;
    en_acc      = en_back;
    en_wb       = en_back;
    fwd_a       = rst ? FWD_RF : fa;
    fwd_b       = rst ? FWD_RF : fb;
    mem_timeout = to_q && !rst;
  end

  // Next-state: a redirect seen during a stall is parked in pend until the stall releases
  always_comb begin
    cnt_inc = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
    state_d = rst ? RUN : stall ? MEM_WAIT : (exe_redirect || pend_q) ? REDIRECT : RUN;
    pend_d  = stall && (pend_q || exe_redirect || in_redir);
    cnt_d   = stall ? cnt_inc : 8'd0;
    to_d    = !rst && (to_q || (stall && cnt_inc == 8'(MEM_TIMEOUT)));
  end

  // Registered controller state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      cnt_q   <= 8'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Free-running wrap-around counters of front-end stall cycles and taken redirects
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= 32'd0;
      perf_flushes      <= 32'd0;
    end else begin
      perf_stall_cycles <= perf_stall_cycles + {31'd0, !en_if};
      perf_flushes      <= perf_flushes + {31'd0, !stall && exe_redirect};
    end
  end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] de_rs1, de_rs2, exe_rd, acc_rd;
  logic de_use_rs1, de_use_rs2, exe_wb_en, exe_is_load, exe_redirect;
  logic acc_wb_en, acc_mem_req, dmem_ready, imem_ready;
  logic en_if, en_de, en_exe, en_acc, en_wb, flush_de, bubble_exe, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [6:0] ctl;
  int total = 0;
  int bad = 0;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flushes;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(3)) dut (
    .clk(clk), .rst(rst),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2),
    .exe_rd(exe_rd), .exe_wb_en(exe_wb_en), .exe_is_load(exe_is_load), .exe_redirect(exe_redirect),
    .acc_rd(acc_rd), .acc_wb_en(acc_wb_en), .acc_mem_req(acc_mem_req), .dmem_ready(dmem_ready),
    .imem_ready(imem_ready),
    .en_if(en_if), .en_de(en_de), .en_exe(en_exe), .en_acc(en_acc), .en_wb(en_wb),
    .flush_de(flush_de), .bubble_exe(bubble_exe), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_timeout(mem_timeout)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
`endif
  );

  assign ctl = {en_if, en_de, en_exe, en_acc, en_wb, flush_de, bubble_exe};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {de_rs1, de_rs2, exe_rd, acc_rd} = '0;
    {de_use_rs1, de_use_rs2, exe_wb_en, exe_is_load, exe_redirect, acc_wb_en, acc_mem_req} = '0;
    dmem_ready = 1'b1;
    imem_ready = 1'b1;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    de_rs1 = 5'd5; acc_rd = 5'd5; acc_wb_en = 1'b1;
    go(); #2;
    chk("rst_ctl", ctl, 7'b0000011);
    chk("rst_fwd_a", fwd_a, 2'b00);
    chk("rst_timeout", mem_timeout, 1'b0);
    go(); rst = 1'b0; clr(); #2;
    chk("run_ctl", ctl, 7'b1111100);
    go(); exe_is_load = 1; exe_wb_en = 1; exe_rd = 5; de_rs1 = 5; de_use_rs1 = 1; de_rs2 = 1; de_use_rs2 = 1; #2;
    chk("lu_ctl", ctl, 7'b0011101);
    chk("lu_fwd_a", fwd_a, 2'b00);
    go(); clr(); acc_rd = 5; acc_wb_en = 1; de_rs1 = 5; de_use_rs1 = 1; #2;
    chk("lu_next_ctl", ctl, 7'b1111100);
    chk("lu_next_fwd_a", fwd_a, 2'b10);
    go(); clr(); exe_is_load = 1; exe_wb_en = 1; exe_rd = 9; de_rs1 = 9; de_use_rs1 = 0; #2;
    chk("lu_unused_rs_ctl", ctl, 7'b1111100);
    go(); clr(); exe_wb_en = 1; exe_rd = 7; de_rs2 = 7; de_use_rs2 = 1; acc_wb_en = 1; acc_rd = 7; #2;
    chk("fwd_exe_b", fwd_b, 2'b01);
    chk("fwd_exe_ctl", ctl, 7'b1111100);
    go(); clr(); exe_wb_en = 1; exe_rd = 0; de_rs2 = 0; de_use_rs2 = 1; acc_wb_en = 1; acc_rd = 0; #2;
    chk("fwd_x0_b", fwd_b, 2'b00);
    go(); clr(); exe_redirect = 1; #2;
    chk("redir_c0", ctl, 7'b1111111);
    go(); clr(); #2;
    chk("redir_c1", ctl, 7'b1111110);
    go(); #2;
    chk("redir_done", ctl, 7'b1111100);
    go(); acc_mem_req = 1; dmem_ready = 0; exe_redirect = 1; #2;
    chk("mw_c1", ctl, 7'b0000000);
    go(); #2;
    chk("mw_c2", ctl, 7'b0000000);
    go(); #2;
    chk("mw_c3", ctl, 7'b0000000);
    chk("mw_c3_timeout", mem_timeout, 1'b0);
    go(); #2;
    chk("mw_c4", ctl, 7'b0000000);
    chk("mw_c4_timeout", mem_timeout, 1'b1);
    go(); dmem_ready = 1; #2;
    chk("mw_release", ctl, 7'b1111111);
    go(); clr(); #2;
    chk("mw_redirect", ctl, 7'b1111110);
    go(); #2;
    chk("mw_back_run", ctl, 7'b1111100);
    chk("timeout_sticky", mem_timeout, 1'b1);
    go(); acc_mem_req = 1; dmem_ready = 0; exe_redirect = 1; #2;
    chk("pend_c1", ctl, 7'b0000000);
    go(); exe_redirect = 0; #2;
    chk("pend_c2", ctl, 7'b0000000);
    go(); dmem_ready = 1; #2;
    chk("pend_release", ctl, 7'b1111100);
    go(); clr(); #2;
    chk("pend_redirect", ctl, 7'b1111110);
    go(); imem_ready = 0; #2;
    chk("fetch_wait", ctl, 7'b0111110);
    go(); clr(); exe_redirect = 1; #2;
    chk("dbl_c0", ctl, 7'b1111111);
    go(); #2;
    chk("dbl_c1", ctl, 7'b1111111);
    go(); clr(); #2;
    chk("dbl_c2", ctl, 7'b1111110);
    go(); acc_mem_req = 1; dmem_ready = 0; exe_redirect = 1; #2;
    chk("rstmw_stall", ctl, 7'b0000000);
    go(); rst = 1; #2;
    chk("rstmw_rst_ctl", ctl, 7'b0000011);
    chk("rstmw_rst_timeout", mem_timeout, 1'b0);
    go(); rst = 0; clr(); #2;
    chk("rstmw_run", ctl, 7'b1111100);
    chk("rstmw_timeout", mem_timeout, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall_rst", perf_stall_cycles, 32'd0);
    chk("perf_flush_rst", perf_flushes, 32'd0);
`endif
    go(); #2;
    chk("rstmw_no_pend", ctl, 7'b1111100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
